// File: rtl/secuenciador_envio_pkg.sv
// Shared definitions for the debug-dump frame sequencer: frame size and FSM encoding.
package secuenciador_envio_pkg;

    localparam int unsigned DEBUG_FRAME_BYTES = 148;
    localparam int unsigned BYTE_W            = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/secuenciador_envio.sv
// Streams a snapshotted debug frame to the UART TX one byte per handshake, byte 0 first.
module secuenciador_envio
    import secuenciador_envio_pkg::*;
#(
    parameter int unsigned N_BYTES = DEBUG_FRAME_BYTES,
    parameter int unsigned IDX_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BYTE_W*N_BYTES-1:0]   buffer_envio,
    input  logic                        start,
    input  logic                        tx_done_tick,
    output logic                        tx_start,
    output logic [BYTE_W-1:0]           tx_data,
    output logic [IDX_W-1:0]            byte_idx,
    output logic                        busy,
    output logic                        done_tick
);

    localparam int unsigned      FRAME_W  = BYTE_W * N_BYTES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [FRAME_W-1:0]  r_shreg;
    logic [FRAME_W-1:0]  w_shreg_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                r_tx_start;
    logic                w_tx_start_nxt;
    logic [BYTE_W-1:0]   r_tx_data;
    logic [BYTE_W-1:0]   w_tx_data_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done_tick;
    logic                w_done_tick_nxt;

    // State, frame shift register and Moore outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_idx       <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_busy      <= 1'b0;
            r_done_tick <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_idx       <= w_idx_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_busy      <= w_busy_nxt;
            r_done_tick <= w_done_tick_nxt;
        end
    end

    // Next state; outputs are decoded from the next state so they register in step with it
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_idx_nxt   = r_idx;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_shreg_nxt = buffer_envio;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (tx_done_tick) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_shreg_nxt = r_shreg >> BYTE_W;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = ST_SEND;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        w_tx_start_nxt  = (w_state_nxt == ST_SEND);
        w_tx_data_nxt   = w_tx_start_nxt ? w_shreg_nxt[BYTE_W-1:0] : r_tx_data;
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_done_tick_nxt = (w_state_nxt == ST_DONE);
    end

    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign byte_idx  = r_idx;
    assign busy      = r_busy;
    assign done_tick = r_done_tick;

endmodule

// File: tb/tb_secuenciador_envio.sv
// Randomized self-checking bench for secuenciador_envio with a 10-cycle UART handshake model.
module tb_secuenciador_envio;
    import secuenciador_envio_pkg::*;

    localparam int NB = int'(DEBUG_FRAME_BYTES);
    localparam int FW = 8 * NB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          tick_uart = 1'b0;
    logic          tick_force = 1'b0;
    logic          uart_en = 1'b0;
    logic          tx_done_tick;
    logic [FW-1:0] buf_envio = '0;
    logic          tx_start, busy, done_tick;
    logic [7:0]    tx_data;
    logic [7:0]    byte_idx;

    logic          start1 = 1'b0;
    logic          tick1 = 1'b0;
    logic [7:0]    buf1 = 8'h3C;
    logic          tx_start1, busy1, done_tick1;
    logic [7:0]    tx_data1;
    logic [0:0]    byte_idx1;

    assign tx_done_tick = tick_uart | tick_force;

    secuenciador_envio #(.N_BYTES(NB), .IDX_W(8)) dut (
        .clk(clk), .reset(reset), .buffer_envio(buf_envio), .start(start),
        .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_data(tx_data),
        .byte_idx(byte_idx), .busy(busy), .done_tick(done_tick)
    );

    secuenciador_envio #(.N_BYTES(1), .IDX_W(1)) dut1 (
        .clk(clk), .reset(reset), .buffer_envio(buf1), .start(start1),
        .tx_done_tick(tick1), .tx_start(tx_start1), .tx_data(tx_data1),
        .byte_idx(byte_idx1), .busy(busy1), .done_tick(done_tick1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int cnt = 0;
    int n_tx1 = 0;
    int n_done1 = 0;
    logic [7:0] tx_data_q[$];
    int         tx_idx_q[$];
    int         tx_cyc_q[$];
    int         done_q[$];
    int         tick_q[$];
    int         idle_q[$];
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output recorder plus UART model: done tick 10 cycles after each tx_start
    always @(negedge clk) begin
        tick_uart = 1'b0;
        if (tx_start) begin
            tx_data_q.push_back(tx_data);
            tx_idx_q.push_back(int'(byte_idx));
            tx_cyc_q.push_back(cyc);
        end
        if (done_tick) done_q.push_back(cyc);
        if (!busy) idle_q.push_back(cyc);
        if (tx_start1) n_tx1++;
        if (done_tick1) n_done1++;
        if (!uart_en) cnt = 0;
        else if (tx_start) cnt = 10;
        else if (cnt != 0) begin
            cnt--;
            if (cnt == 0) begin
                tick_uart = 1'b1;
                tick_q.push_back(cyc);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] r;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = 8'($urandom);
        return r;
    endfunction

    function automatic void add_frame(input logic [FW-1:0] f);
        for (int i = 0; i < NB; i++) exp_q.push_back(f[8*i +: 8]);
    endfunction

    task automatic wait_done(input int base, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_q.size() >= base + n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start1 = 1'b0; tick_force = 1'b0; tick1 = 1'b0; uart_en = 1'b0;
        repeat (3) step();
        reset = 1'b0; uart_en = 1'b1;
        n_checks++;
        if ({tx_start, busy, done_tick} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl got start/busy/done=%b exp 000", {tx_start, busy, done_tick});
        end
        n_checks++;
        if ({tx_data, byte_idx} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data got data=%h idx=%0d exp 00/0", tx_data, byte_idx);
        end
        n_checks++;
        if ({tx_start1, busy1, done_tick1, tx_data1, byte_idx1} !== 12'h000) begin
            n_fail++; $display("FAIL reset_n1 got %b exp all zero", {tx_start1, busy1, done_tick1, tx_data1, byte_idx1});
        end
    endtask

    task automatic test_basic();
        int tb0, d0, k0, c0, n;
        bit ok;
        for (int i = 0; i < NB; i++) buf_envio[8*i +: 8] = 8'(i);
        exp_q.delete(); add_frame(buf_envio);
        tb0 = tx_data_q.size(); d0 = done_q.size(); k0 = tick_q.size();
        start = 1'b1; c0 = cyc; step(); start = 1'b0;
        wait_done(d0, 1, 3000, ok);
        step(); step();
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout no done_tick within budget"); end
        n = tx_data_q.size() - tb0;
        n_checks++;
        if (n != NB) begin n_fail++; $display("FAIL basic_count got %0d bytes exp %0d", n, NB); end
        for (int i = 0; i < n && i < NB; i++) begin
            n_checks++;
            if (tx_data_q[tb0+i] !== exp_q[i] || tx_idx_q[tb0+i] != i) begin
                n_fail++;
                $display("FAIL basic_byte%0d got data=%h idx=%0d exp data=%h idx=%0d", i, tx_data_q[tb0+i], tx_idx_q[tb0+i], exp_q[i], i);
            end
        end
        if (n > 0) begin
            n_checks++;
            if (tx_cyc_q[tb0] != c0 + 1) begin
                n_fail++; $display("FAIL basic_start_latency got cycle %0d exp %0d", tx_cyc_q[tb0], c0 + 1);
            end
        end
        for (int i = 1; i < n && i < NB && (k0 + i - 1) < tick_q.size(); i++) begin
            n_checks++;
            if (tx_cyc_q[tb0+i] != tick_q[k0+i-1] + 1) begin
                n_fail++; $display("FAIL basic_handshake_latency byte%0d got cycle %0d exp %0d", i, tx_cyc_q[tb0+i], tick_q[k0+i-1] + 1);
            end
        end
        if (done_q.size() > d0 && tick_q.size() >= k0 + NB) begin
            n_checks++;
            if (done_q[d0] != tick_q[k0+NB-1] + 1) begin
                n_fail++; $display("FAIL basic_done_latency got cycle %0d exp %0d", done_q[d0], tick_q[k0+NB-1] + 1);
            end
        end
        n_checks++;
        if (done_q.size() - d0 != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_end got done_ticks=%0d busy=%b exp 1/0", done_q.size() - d0, busy);
        end
    endtask

    task automatic test_snapshot();
        int tb0, d0, n;
        bit ok;
        logic [FW-1:0] snap;
        for (int i = 0; i < NB; i++) buf_envio[8*i +: 8] = 8'hA5;
        snap = buf_envio;
        exp_q.delete(); add_frame(snap);
        tb0 = tx_data_q.size(); d0 = done_q.size();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < NB; i++) buf_envio[8*i +: 8] = 8'h5A;
        wait_done(d0, 1, 3000, ok);
        step();
        n = tx_data_q.size() - tb0;
        n_checks++;
        if (!ok || n != NB) begin n_fail++; $display("FAIL snap_count got %0d bytes done=%b exp %0d", n, ok, NB); end
        for (int i = 0; i < n && i < NB; i++) begin
            n_checks++;
            if (tx_data_q[tb0+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL snap_byte%0d got %h exp %h", i, tx_data_q[tb0+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_busy();
        int tb0, d0, d1, tb1, n, post;
        bit p3, p147, pd, ok;
        logic [FW-1:0] f;
        f = rand_frame(); buf_envio = f;
        exp_q.delete(); add_frame(f);
        tb0 = tx_data_q.size(); d0 = done_q.size();
        start = 1'b1; step(); start = 1'b0;
        p3 = 1'b0; p147 = 1'b0; pd = 1'b0; post = 0;
        for (int t = 0; t < 4000 && post < 20; t++) begin
            step(); start = 1'b0;
            n = tx_data_q.size() - tb0;
            if (pd) post++;
            if (!p3 && n == 4) begin start = 1'b1; p3 = 1'b1; end
            if (!p147 && n == NB) begin start = 1'b1; p147 = 1'b1; end
            if (!pd && done_tick) begin start = 1'b1; pd = 1'b1; end
        end
        start = 1'b0;
        n = tx_data_q.size() - tb0;
        n_checks++;
        if (!pd || n != NB || done_q.size() - d0 != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_ignore got bytes=%0d done_ticks=%0d busy=%b exp %0d/1/0", n, done_q.size() - d0, busy, NB);
        end
        for (int i = 0; i < n && i < NB; i++) begin
            n_checks++;
            if (tx_data_q[tb0+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL busy_byte%0d got %h exp %h", i, tx_data_q[tb0+i], exp_q[i]);
            end
        end
        // second frame, restarted in the IDLE cycle right after DONE
        f = rand_frame(); buf_envio = f;
        start = 1'b1; step(); start = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            step();
            if (done_tick) begin ok = 1'b1; break; end
        end
        step();
        n_checks++;
        if (!ok || busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle_after_done got done=%b busy=%b exp 1/0", ok, busy); end
        tb1 = tx_data_q.size(); d1 = done_q.size();
        start = 1'b1; step(); start = 1'b0;
        n_checks++;
        if (tx_start !== 1'b1 || byte_idx !== 8'd0 || tx_data !== f[7:0]) begin
            n_fail++; $display("FAIL busy_restart got start=%b idx=%0d data=%h exp 1/0/%h", tx_start, byte_idx, tx_data, f[7:0]);
        end
        wait_done(d1, 1, 3000, ok);
        step();
        n = tx_data_q.size() - tb1;
        n_checks++;
        if (!ok || n != NB || tx_data_q[tx_data_q.size()-1] !== f[FW-1 -: 8]) begin
            n_fail++; $display("FAIL busy_restart_frame got bytes=%0d last=%h exp %0d/%h", n, tx_data_q[tx_data_q.size()-1], NB, f[FW-1 -: 8]);
        end
    endtask

    task automatic test_reset_mid();
        int tb0, tb1, d1, n;
        bit ok;
        logic [FW-1:0] f;
        f = rand_frame(); buf_envio = f;
        tb0 = tx_data_q.size();
        start = 1'b1; step(); start = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            step();
            if (tx_data_q.size() - tb0 == 51 && !tx_start) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || byte_idx !== 8'd50 || tx_data !== f[50*8 +: 8]) begin
            n_fail++; $display("FAIL rmid_wait50 got reached=%b idx=%0d data=%h exp 1/50/%h", ok, byte_idx, tx_data, f[50*8 +: 8]);
        end
        reset = 1'b1; uart_en = 1'b0; step(); reset = 1'b0;
        n_checks++;
        if ({tx_start, tx_data, byte_idx, busy, done_tick} !== 19'd0) begin
            n_fail++; $display("FAIL rmid_outputs got start=%b data=%h idx=%0d busy=%b done=%b exp all 0", tx_start, tx_data, byte_idx, busy, done_tick);
        end
        tb1 = tx_data_q.size(); d1 = done_q.size();
        repeat (40) step();
        n_checks++;
        if (tx_data_q.size() != tb1 || done_q.size() != d1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rmid_quiet got new_tx=%0d new_done=%0d busy=%b exp 0/0/0", tx_data_q.size() - tb1, done_q.size() - d1, busy);
        end
        uart_en = 1'b1;
        f = rand_frame(); buf_envio = f;
        exp_q.delete(); add_frame(f);
        start = 1'b1; step(); start = 1'b0;
        n_checks++;
        if (tx_start !== 1'b1 || byte_idx !== 8'd0 || tx_data !== f[7:0]) begin
            n_fail++; $display("FAIL rmid_restart got start=%b idx=%0d data=%h exp 1/0/%h", tx_start, byte_idx, tx_data, f[7:0]);
        end
        wait_done(d1, 1, 3000, ok);
        step();
        n = tx_data_q.size() - tb1;
        n_checks++;
        if (!ok || n != NB) begin n_fail++; $display("FAIL rmid_count got %0d bytes done=%b exp %0d", n, ok, NB); end
        for (int i = 0; i < n && i < NB; i++) begin
            n_checks++;
            if (tx_data_q[tb1+i] !== exp_q[i] || tx_idx_q[tb1+i] != i) begin
                n_fail++; $display("FAIL rmid_byte%0d got %h/%0d exp %h/%0d", i, tx_data_q[tb1+i], tx_idx_q[tb1+i], exp_q[i], i);
            end
        end
    endtask

    task automatic test_spurious();
        int tb0, d0, k0, n;
        bit ok;
        logic [FW-1:0] f;
        tb0 = tx_data_q.size(); d0 = done_q.size();
        tick_force = 1'b1; step(); tick_force = 1'b0;
        step(); step();
        n_checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0 || tx_data_q.size() != tb0 || done_q.size() != d0) begin
            n_fail++; $display("FAIL spur_idle got busy=%b start=%b new_tx=%0d exp 0/0/0", busy, tx_start, tx_data_q.size() - tb0);
        end
        f = rand_frame(); buf_envio = f;
        exp_q.delete(); add_frame(f);
        k0 = tick_q.size();
        start = 1'b1; step(); start = 1'b0;
        n_checks++;
        if (tx_start !== 1'b1) begin n_fail++; $display("FAIL spur_send got start=%b exp 1", tx_start); end
        tick_force = 1'b1; step(); tick_force = 1'b0;
        n_checks++;
        if (tx_start !== 1'b0 || byte_idx !== 8'd0 || busy !== 1'b1 || tx_data !== f[7:0]) begin
            n_fail++; $display("FAIL spur_in_send got start=%b idx=%0d busy=%b data=%h exp 0/0/1/%h", tx_start, byte_idx, busy, tx_data, f[7:0]);
        end
        wait_done(d0, 1, 3000, ok);
        step();
        n = tx_data_q.size() - tb0;
        n_checks++;
        if (!ok || n != NB) begin n_fail++; $display("FAIL spur_count got %0d bytes done=%b exp %0d", n, ok, NB); end
        for (int i = 0; i < n && i < NB; i++) begin
            n_checks++;
            if (tx_data_q[tb0+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL spur_byte%0d got %h exp %h", i, tx_data_q[tb0+i], exp_q[i]);
            end
        end
        if (n > 1 && tick_q.size() > k0) begin
            n_checks++;
            if (tx_cyc_q[tb0+1] != tick_q[k0] + 1) begin
                n_fail++; $display("FAIL spur_second_byte got cycle %0d exp %0d", tx_cyc_q[tb0+1], tick_q[k0] + 1);
            end
        end
    endtask

    task automatic test_n1();
        int b, nd;
        b = n_tx1; nd = n_done1;
        tick1 = 1'b1; step(); tick1 = 1'b0; step();
        n_checks++;
        if (busy1 !== 1'b0 || n_tx1 != b) begin n_fail++; $display("FAIL n1_idle_tick got busy=%b tx=%0d exp 0/0", busy1, n_tx1 - b); end
        start1 = 1'b1; step(); start1 = 1'b0;
        n_checks++;
        if (tx_start1 !== 1'b1 || tx_data1 !== 8'h3C || byte_idx1 !== 1'b0) begin
            n_fail++; $display("FAIL n1_send got start=%b data=%h idx=%0d exp 1/3c/0", tx_start1, tx_data1, byte_idx1);
        end
        tick1 = 1'b1; step(); tick1 = 1'b0;
        repeat (3) step();
        n_checks++;
        if (tx_start1 !== 1'b0 || busy1 !== 1'b1 || done_tick1 !== 1'b0) begin
            n_fail++; $display("FAIL n1_wait got start=%b busy=%b done=%b exp 0/1/0", tx_start1, busy1, done_tick1);
        end
        tick1 = 1'b1; step(); tick1 = 1'b0;
        n_checks++;
        if (done_tick1 !== 1'b1 || busy1 !== 1'b1) begin
            n_fail++; $display("FAIL n1_done got done=%b busy=%b exp 1/1", done_tick1, busy1);
        end
        step();
        n_checks++;
        if (done_tick1 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++; $display("FAIL n1_idle got done=%b busy=%b exp 0/0", done_tick1, busy1);
        end
        repeat (3) step();
        n_checks++;
        if (n_tx1 - b != 1 || n_done1 - nd != 1) begin
            n_fail++; $display("FAIL n1_counts got tx=%0d done=%0d exp 1/1", n_tx1 - b, n_done1 - nd);
        end
    endtask

    task automatic test_back_to_back();
        int tb0, d0, i0, n, idle_n;
        bit ok;
        logic [FW-1:0] fa, fb;
        fa = rand_frame(); fb = rand_frame();
        buf_envio = fa;
        exp_q.delete(); add_frame(fa); add_frame(fb);
        tb0 = tx_data_q.size(); d0 = done_q.size(); i0 = idle_q.size();
        start = 1'b1; step();
        buf_envio = fb;
        ok = 1'b0;
        for (int t = 0; t < 6000; t++) begin
            step();
            if (done_tick && done_q.size() - d0 == 2) begin ok = 1'b1; break; end
        end
        start = 1'b0;
        repeat (20) step();
        n = tx_data_q.size() - tb0;
        n_checks++;
        if (!ok || n != 2 * NB || done_q.size() - d0 != 2) begin
            n_fail++; $display("FAIL b2b_count got bytes=%0d done_ticks=%0d exp %0d/2", n, done_q.size() - d0, 2 * NB);
        end
        for (int i = 0; i < n && i < 2 * NB; i++) begin
            n_checks++;
            if (tx_data_q[tb0+i] !== exp_q[i] || tx_idx_q[tb0+i] != i % NB) begin
                n_fail++; $display("FAIL b2b_byte%0d got %h/%0d exp %h/%0d", i, tx_data_q[tb0+i], tx_idx_q[tb0+i], exp_q[i], i % NB);
            end
        end
        if (n > NB && done_q.size() > d0) begin
            idle_n = 0;
            for (int i = i0; i < idle_q.size(); i++)
                if (idle_q[i] > done_q[d0] && idle_q[i] < tx_cyc_q[tb0+NB]) idle_n++;
            n_checks++;
            if (tx_cyc_q[tb0+NB] - done_q[d0] != 2 || idle_n != 1) begin
                n_fail++; $display("FAIL b2b_gap got gap=%0d idle_cycles=%0d exp 2/1", tx_cyc_q[tb0+NB] - done_q[d0], idle_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_start_busy();
        test_reset_mid();
        test_spurious();
        test_n1();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
